cdc_hs_tx: RTL and testbench

Source-side (transmitter) end of a toggle req/ack handshake carrying a DATA_W-bit word across a clock domain boundary.
- Runs entirely in the source clock domain.
- Accepts a word on a valid/ready interface, holds it stable on xfer_data and toggles xfer_req.
- Synchronizes the receiver's returned xfer_ack toggle through an N-flop chain and completes the transfer when ack matches req.
- Pairs with a destination-domain receiver that double-flops xfer_req, samples xfer_data and toggles xfer_ack back.

---
 rtl/cdc_pkg.sv | 22 ++
 rtl/cdc_sync_bit.sv | 40 ++++
 rtl/cdc_hs_tx.sv | 126 ++++++++++++
 tb/tb_cdc_hs_tx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : cdc_pkg                                                    |
// | Description : Shared definitions for the toggle req/ack CDC handshake.   |
// |               Holds the transmitter FSM state type, its state encodings  |
// |               and the minimum synchronizer depth.                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package cdc_pkg;

   // Fewer than two flops leaves no settling time for a metastable sample.
   localparam int CDC_SYNC_STAGES_MIN = 2;

   // Transmitter FSM state, kept as plain logic constants so older
   // tools and netlists see a fixed 1-bit encoding.
   typedef logic [0:0] cdc_state_t;

   localparam cdc_state_t IDLE     = 1'b0;
   localparam cdc_state_t WAIT_ACK = 1'b1;

endpackage : cdc_pkg
`default_nettype wire

// File: rtl/cdc_sync_bit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cdc_sync_bit                                               |
// | Description : Single-bit multi-flop synchronizer into the clk domain.    |
// |               Plain shift chain, no logic between stages.                |
// | Ports       : clk      - destination clock                               |
// |               reset_n  - synchronous active-low reset (all stages -> 0)  |
// |               async_in - bit from a foreign clock domain                 |
// |               sync_out - last stage of the chain                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cdc_sync_bit
   import cdc_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic async_in,
   output logic sync_out
);

   // Never build a chain shorter than the safe minimum.
   localparam int C_STAGES = (SYNC_STAGES < CDC_SYNC_STAGES_MIN) ?
                             CDC_SYNC_STAGES_MIN : SYNC_STAGES;

   logic [C_STAGES-1:0] r_sync;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[C_STAGES-2:0], async_in};
      end
   end

   assign sync_out = r_sync[C_STAGES-1];

endmodule : cdc_sync_bit
`default_nettype wire

// File: rtl/cdc_hs_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cdc_hs_tx                                                  |
// | Description : Source-side end of a toggle req/ack handshake. Accepts a   |
// |               word on valid/ready, holds it on xfer_data, toggles        |
// |               xfer_req and waits until the synchronized xfer_ack toggle  |
// |               matches xfer_req before accepting the next word.           |
// | Ports       : clk, reset_n (sync, active-low)                            |
// |               in_valid/in_ready/in_data  - upstream word interface       |
// |               xfer_req/xfer_data         - to destination (registered)   |
// |               xfer_ack                   - from destination (async)      |
// |               busy, done_pulse, timeout_err - status                     |
// | Options     : `define CDC_HS_TX_TIMEOUT_EN adds a sticky timeout flag    |
// |               raised after TIMEOUT_CYC cycles in WAIT_ACK.               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cdc_hs_tx
   import cdc_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              xfer_req,
   output logic [DATA_W-1:0] xfer_data,
   input  logic              xfer_ack,
   output logic              busy,
   output logic              done_pulse,
   output logic              timeout_err
);

   cdc_state_t        r_state;
   logic              r_xfer_req;
   logic [DATA_W-1:0] r_xfer_data;
   logic              r_done_pulse;
   logic              w_ack_s;

   cdc_sync_bit #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_ack_sync (
      .clk      (clk),
      .reset_n  (reset_n),
      .async_in (xfer_ack),
      .sync_out (w_ack_s)
   );

   // A word is only ever taken in IDLE; completion and a new accept can
   // therefore never share an edge.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state      <= IDLE;
         r_xfer_req   <= 1'b0;
         r_xfer_data  <= '0;
         r_done_pulse <= 1'b0;
      end else begin
         r_done_pulse <= 1'b0;
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_xfer_data <= in_data;
                  r_xfer_req  <= ~r_xfer_req;
                  r_state     <= WAIT_ACK;
               end
            end
            WAIT_ACK: begin
               // Receiver has echoed our toggle once the synced ack equals req.
               if (w_ack_s == r_xfer_req) begin
                  r_state      <= IDLE;
                  r_done_pulse <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Ready is forced high while reset is asserted so upstream sees the
   // post-reset value without waiting for the first edge.
   assign in_ready   = !reset_n || (r_state == IDLE);
   assign busy       = (r_state == WAIT_ACK);
   assign xfer_req   = r_xfer_req;
   assign xfer_data  = r_xfer_data;
   assign done_pulse = r_done_pulse;

`ifdef CDC_HS_TX_TIMEOUT_EN
   localparam int                C_TO_W     = $clog2(TIMEOUT_CYC + 1);
   localparam logic [C_TO_W-1:0] C_TO_LIMIT = C_TO_W'(TIMEOUT_CYC);
   localparam logic [C_TO_W-1:0] C_TO_ONE   = C_TO_W'(1);

   logic [C_TO_W-1:0] r_to_cnt;
   logic              r_timeout_err;

   // Counter sits at zero in IDLE, so it is clear on every WAIT_ACK entry.
   // The flag rises on the same edge the counter reaches the limit.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_to_cnt      <= '0;
         r_timeout_err <= 1'b0;
      end else if (r_state == IDLE) begin
         r_to_cnt <= '0;
      end else begin
         if (r_to_cnt != C_TO_LIMIT) begin
            r_to_cnt <= r_to_cnt + C_TO_ONE;
         end
         if (r_to_cnt >= (C_TO_LIMIT - C_TO_ONE)) begin
            r_timeout_err <= 1'b1;
         end
      end
   end

   assign timeout_err = r_timeout_err;
`else
   // Always 0; the parameter is referenced only so both builds expose an
   // identical, warning-free parameter list.
   assign timeout_err = 1'b0 && (TIMEOUT_CYC != 0);
`endif

endmodule : cdc_hs_tx
`default_nettype wire

// File: tb/tb_cdc_hs_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cdc_hs_tx                                               |
// | Description : Directed self-checking bench for cdc_hs_tx. The bench      |
// |               plays the destination receiver by driving xfer_ack.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_cdc_hs_tx;

   localparam int DATA_W      = 8;
   localparam int SYNC_STAGES = 2;
   localparam int TIMEOUT_CYC = 16;

`ifdef CDC_HS_TX_TIMEOUT_EN
   localparam logic TO_EN = 1'b1;
`else
   localparam logic TO_EN = 1'b0;
`endif

   logic              clk;
   logic              reset_n;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              xfer_req;
   logic [DATA_W-1:0] xfer_data;
   logic              xfer_ack;
   logic              busy;
   logic              done_pulse;
   logic              timeout_err;

   int total = 0;
   int bad   = 0;

   cdc_hs_tx #(
      .DATA_W      (DATA_W),
      .SYNC_STAGES (SYNC_STAGES),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .xfer_req    (xfer_req),
      .xfer_data   (xfer_data),
      .xfer_ack    (xfer_ack),
      .busy        (busy),
      .done_pulse  (done_pulse),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge and settle 1 ns past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] words [3];
      logic       exp_req;
      words = '{8'h11, 8'h22, 8'h33};

      // ---------------- reset ----------------
      reset_n  = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      xfer_ack = 1'b0;
      #1;
      chk("rst_ready_comb", in_ready, 1);
      step();
      step();
      chk("rst_req", xfer_req, 0);
      chk("rst_data", xfer_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done_pulse, 0);
      chk("rst_to", timeout_err, 0);
      chk("rst_ready", in_ready, 1);
      reset_n = 1'b1;
      step();
      chk("idle_busy", busy, 0);

      // ---------------- 1: accept 0xA5 ----------------
      in_valid = 1'b1;
      in_data  = 8'hA5;
      step();
      chk("t1_data", xfer_data, 8'hA5);
      chk("t1_req", xfer_req, 1);
      chk("t1_busy", busy, 1);
      chk("t1_ready", in_ready, 0);

      // ---------------- 4: new data ignored in WAIT_ACK ----------------
      in_data = 8'hFF;
      step();
      chk("t4_hold_data", xfer_data, 8'hA5);
      chk("t4_ready", in_ready, 0);
      chk("t4_done", done_pulse, 0);

      // ---------------- 2: ack round trip ----------------
      xfer_ack = 1'b1;
      step();                                   // E0: stage0 captures
      chk("t2_done_e0", done_pulse, 0);
      step();                                   // E0+1: ack_s = 1
      chk("t2_done_e1", done_pulse, 0);
      chk("t2_busy_e1", busy, 1);
      step();                                   // E0+2: completion
      chk("t2_done_e2", done_pulse, 1);
      chk("t2_ready_e2", in_ready, 1);
      chk("t2_req_e2", xfer_req, 1);
      chk("t2_busy_e2", busy, 0);
      step();                                   // pending 0xFF now taken
      chk("t4_done_once", done_pulse, 0);
      chk("t4_data_ff", xfer_data, 8'hFF);
      chk("t4_req", xfer_req, 0);
      chk("t4_busy", busy, 1);
      xfer_ack = 1'b0;
      step();
      step();
      chk("t4_done_early", done_pulse, 0);
      step();
      chk("t4_done", done_pulse, 1);
      in_valid = 1'b0;
      step();
      chk("t4_done_clr", done_pulse, 0);
      chk("t4_idle_busy", busy, 0);
      chk("t4_idle_req", xfer_req, 0);

      // ---------------- 3: back-to-back 0x11 0x22 0x33 ----------------
      exp_req  = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = words[i];
         step();                                // accept edge
         exp_req = ~exp_req;
         chk("t3_data", xfer_data, words[i]);
         chk("t3_req", xfer_req, exp_req);
         chk("t3_busy", busy, 1);
         xfer_ack = exp_req;                    // receiver echoes toggle
         step();
         chk("t3_done_a", done_pulse, 0);
         step();
         chk("t3_done_b", done_pulse, 0);
         step();
         chk("t3_done", done_pulse, 1);
         chk("t3_ready", in_ready, 1);
         if (i == 2) in_valid = 1'b0;
      end
      step();
      chk("t3_end_busy", busy, 0);
      chk("t3_end_done", done_pulse, 0);
      chk("t3_end_data", xfer_data, 8'h33);
      chk("t3_end_req", xfer_req, 1);

      // ---------------- 5: reset mid-transfer ----------------
      in_valid = 1'b1;
      in_data  = 8'hC3;
      step();
      in_valid = 1'b0;
      chk("t5_req", xfer_req, 0);
      chk("t5_data", xfer_data, 8'hC3);
      xfer_ack = 1'b0;                          // receiver completes
      step();
      step();
      step();
      chk("t5_done", done_pulse, 1);
      in_valid = 1'b1;
      in_data  = 8'h5A;
      step();
      in_valid = 1'b0;
      chk("t5_inflight_req", xfer_req, 1);
      chk("t5_inflight_busy", busy, 1);
      reset_n = 1'b0;
      step();
      chk("t5_rst_req", xfer_req, 0);
      chk("t5_rst_data", xfer_data, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_done", done_pulse, 0);
      chk("t5_rst_ready", in_ready, 1);
      reset_n = 1'b1;
      step();
      step();
      step();
      chk("t5_post_done", done_pulse, 0);
      chk("t5_post_busy", busy, 0);

      // ---------------- 6: timeout (flag only with the option) ----------------
      in_valid = 1'b1;
      in_data  = 8'h77;
      step();                                   // accept, req -> 1
      in_valid = 1'b0;
      chk("t6_req", xfer_req, 1);
      for (int k = 0; k < 15; k++) step();      // 15 edges in WAIT_ACK
      chk("t6_to_15", timeout_err, 0);
      step();                                   // 16th edge
      chk("t6_to_16", timeout_err, TO_EN);
      for (int k = 0; k < 5; k++) step();
      chk("t6_to_sticky", timeout_err, TO_EN);
      chk("t6_still_busy", busy, 1);
      xfer_ack = 1'b1;
      step();
      step();
      step();
      chk("t6_done", done_pulse, 1);
      chk("t6_to_after", timeout_err, TO_EN);
      step();
      chk("t6_idle", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_cdc_hs_tx
`default_nettype wire
